// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - seven-segment digit scan controller with tear-free content buffering
// Outputs are registered from next-state so digit_sel and hex_code change on the same edge.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [1:0]              mode_in,
  output logic [3:0]              hex_code,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    scan_done
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHOW  = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;

  localparam logic [1:0] MODE_HEX  = 2'b00;
  localparam logic [1:0] MODE_PASS = 2'b01;
  localparam logic [1:0] MODE_FAIL = 2'b10;

  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d;
  logic [1:0]              act_mode_q, act_mode_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [1:0]              pend_mode_q, pend_mode_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [3:0]              hex_code_q, hex_code_d;
  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic                    scan_done_q, scan_done_d;
  logic                    copy;

  // Fixed words are stored digit 3..0 as nibbles 3..0; digits above 3 always show a dash.
  function automatic logic [3:0] digit_code(input logic [1:0]              mode,
                                            input logic [4*NUM_DIGITS-1:0] val,
                                            input logic [IDX_W-1:0]        i);
    logic [15:0] word;
    logic [3:0]  pos;
    logic [3:0]  code;
    pos = 4'(i);
    case (mode)
      MODE_PASS: word = 16'hBACC;
      MODE_FAIL: word = 16'hDA1E;
      default:   word = 16'hFFFF;
    endcase
    if (mode == MODE_HEX) begin
      code = val[{i, 2'b00} +: 4];
    end else if (pos > 4'd3) begin
      code = 4'hF;
    end else begin
      code = word[{pos[1:0], 2'b00} +: 4];
    end
    return code;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SHOW;
          idx_d   = '0;
          cnt_d   = '0;
        end
        S_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_SHOW;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A load coinciding with a copy bypasses pending so the newest content is never lost.
  always_comb begin
    copy        = scan_done_q || (state_q == S_IDLE);
    act_val_d   = act_val_q;
    act_mode_d  = act_mode_q;
    pend_val_d  = pend_val_q;
    pend_mode_d = pend_mode_q;
    pend_flag_d = pend_flag_q;
    if (load) begin
      pend_val_d  = value_in;
      pend_mode_d = mode_in;
    end
    if (copy) begin
      if (load) begin
        act_val_d  = value_in;
        act_mode_d = mode_in;
      end else if (pend_flag_q) begin
        act_val_d  = pend_val_q;
        act_mode_d = pend_mode_q;
      end
      pend_flag_d = 1'b0;
    end else if (load) begin
      pend_flag_d = 1'b1;
    end
  end

  always_comb begin
    digit_sel_d = '0;
    hex_code_d  = hex_code_q;
    if (state_d == S_SHOW) begin
      digit_sel_d = NUM_DIGITS'(1) << idx_d;
      hex_code_d  = digit_code(act_mode_d, act_val_d, idx_d);
    end
    scan_done_d = (state_d == S_BLANK) && (idx_d == IDX_LAST) && (cnt_d == BLANK_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      act_val_q   <= '0;
      act_mode_q  <= MODE_HEX;
      pend_val_q  <= '0;
      pend_mode_q <= MODE_HEX;
      pend_flag_q <= 1'b0;
      hex_code_q  <= '0;
      digit_sel_q <= '0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      act_val_q   <= act_val_d;
      act_mode_q  <= act_mode_d;
      pend_val_q  <= pend_val_d;
      pend_mode_q <= pend_mode_d;
      pend_flag_q <= pend_flag_d;
      hex_code_q  <= hex_code_d;
      digit_sel_q <= digit_sel_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign hex_code  = hex_code_q;
  assign digit_sel = digit_sel_q;
  assign scan_done = scan_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl against a frame-arithmetic reference model
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int BC    = 1;
  localparam int SLOT  = RD + BC;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [1:0]  mode_in = '0;
  logic [3:0]  hex_code;
  logic [3:0]  digit_sel;
  logic        scan_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] sel;
    logic       done;
    logic [3:0] code;
  } exp_t;
  exp_t sb_q[$];

  seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load),
    .value_in(value_in), .mode_in(mode_in),
    .hex_code(hex_code), .digit_sel(digit_sel), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] char_code(input byte c);
    case (c)
      "P": return 4'hB;
      "A": return 4'hA;
      "S": return 4'hC;
      "F": return 4'hD;
      "I": return 4'h1;
      "L": return 4'hE;
      default: return 4'hF;
    endcase
  endfunction

  // Digit d shows the character at position (3-d) of the word, leftmost digit first.
  function automatic logic [3:0] ref_code(input logic [1:0] mode, input logic [15:0] val, input int d);
    string w;
    case (mode)
      2'd0: return val[d*4 +: 4];
      2'd1: w = "PASS";
      2'd2: w = "FAIL";
      default: w = "----";
    endcase
    return char_code(w.getc(3 - d));
  endfunction

  // Reference model: position in the frame counted from the first lit cycle after enable.
  bit          m_on;
  int          m_pos;
  logic [15:0] m_act_val, m_pend_val;
  logic [1:0]  m_act_mode, m_pend_mode;
  logic [3:0]  m_code;

  initial begin
    exp_t e;
    bit   copy;
    int   d;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_on = 0; m_pos = 0; m_code = '0;
        m_act_val = '0; m_act_mode = '0; m_pend_val = '0; m_pend_mode = '0;
        sb_q.delete();
      end else begin
        copy = !m_on || (m_pos == FRAME - 1);
        if (load) begin
          m_pend_val  = value_in;
          m_pend_mode = mode_in;
        end
        if (copy) begin
          m_act_val  = m_pend_val;
          m_act_mode = m_pend_mode;
        end
        if (!enable) m_on = 0;
        else if (!m_on) begin
          m_on = 1;
          m_pos = 0;
        end else m_pos = (m_pos + 1) % FRAME;
        e.sel = '0;
        if (m_on && (m_pos % SLOT) < RD) begin
          d = m_pos / SLOT;
          e.sel = 4'(1 << d);
          m_code = ref_code(m_act_mode, m_act_val, d);
        end
        e.done = m_on && (m_pos == FRAME - 1);
        e.code = m_code;
        sb_q.push_back(e);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk("digit_sel", 32'(digit_sel), 32'(e.sel));
          chk("scan_done", 32'(scan_done), 32'(e.done));
          chk("hex_code", 32'(hex_code), 32'(e.code));
        end
      end
    end
  end

  task automatic pulse_load(input logic [15:0] v, input logic [1:0] m);
    load = 1'b1;
    value_in = v;
    mode_in = m;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_sel(input logic [3:0] s);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (digit_sel != s && n < 200);
    chk("wait_digit_sel", 32'(digit_sel), 32'(s));
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_done && n < 200);
    chk("wait_scan_done", 32'(scan_done), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_hex_code", 32'(hex_code), 32'd0);
    chk("reset_digit_sel", 32'(digit_sel), 32'd0);
    chk("reset_scan_done", 32'(scan_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    pulse_load(16'h1234, 2'd0);
    enable = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    wait_sel(4'b0010);
    pulse_load(16'($urandom), 2'd1);
    wait_done();
    repeat (FRAME + 2) @(negedge clk);

    wait_sel(4'b0001);
    pulse_load(16'hAAAA, 2'd0);
    wait_sel(4'b0100);
    pulse_load(16'($urandom), 2'd2);
    wait_done();
    repeat (FRAME + 2) @(negedge clk);

    wait_done();
    pulse_load(16'($urandom), 2'd3);
    repeat (FRAME + 2) @(negedge clk);

    wait_sel(4'b0100);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    wait_sel(4'b0010);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hex_code", 32'(hex_code), 32'd0);
    chk("async_rst_digit_sel", 32'(digit_sel), 32'd0);
    chk("async_rst_scan_done", 32'(scan_done), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (FRAME + 3) @(negedge clk);

    repeat (400) begin
      @(negedge clk);
      load     = ($urandom_range(0, 7) == 0);
      value_in = 16'($urandom);
      mode_in  = 2'($urandom_range(0, 3));
      enable   = ($urandom_range(0, 59) != 0);
    end

    @(negedge clk);
    load = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
